// File: rtl/hptdc_readout_fifo.sv
// Multi-channel HPTDC capture buffer: per-channel hold registers, round-robin merge into one circular FIFO, registered valid/ready output.
// Optional HPTDC_FIFO_OVF_MARK_EN inserts an overflow marker word after lost data.
module hptdc_readout_fifo #(
  parameter int         DATA_WIDTH  = 32,
  parameter int         ADDR_WIDTH  = 10,
  parameter int         N_CH        = 2,
  parameter logic [2:0] ACCEPT_TYPE = 3'b010,
  parameter int         AFULL_LEVEL = (2**ADDR_WIDTH) - 16,
  localparam int        CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [N_CH-1:0]            ch_ready,
  output logic [N_CH-1:0]            ch_get,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [CH_W-1:0]            rd_channel,
  output logic [ADDR_WIDTH:0]        level,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [15:0]                drop_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int ENT_W = CH_W + DATA_WIDTH;

  logic [N_CH-1:0]       prev_ready;
  logic [N_CH-1:0]       pending;
  logic [N_CH-1:0]       rise;
  logic [N_CH-1:0]       type_ok;
  logic [N_CH-1:0]       capture;
  logic [N_CH-1:0]       drop;
  logic [N_CH-1:0]       grant;
  logic [DATA_WIDTH-1:0] hold [N_CH];

  logic [ENT_W-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;

  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       rr_next;
  logic [CH_W-1:0]       win_ch;
  logic                  win_vld;
  logic                  mark_sel;
  logic                  wr_en;
  logic                  ld;
  logic [ENT_W-1:0]      wr_ent;
  logic [16:0]           n_drop;
  logic [16:0]           drop_sum;

  // Per-channel edge detect and capture qualification; flush-cycle edges are discarded.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign rise[i]    = ch_ready[i] & ~prev_ready[i];
    assign type_ok[i] = (ch_data[i*DATA_WIDTH+29 +: 3] == ACCEPT_TYPE);
    assign capture[i] = rise[i] & type_ok[i] & ~pending[i] & ~flush;
    assign drop[i]    = rise[i] & type_ok[i] &  pending[i] & ~flush;
    assign ch_get[i]  = ch_ready[i] & ~pending[i];
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_CH; i++) begin
      n_drop = n_drop + 17'(drop[i]);
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + n_drop;

  function automatic int rr_idx(input logic [CH_W-1:0] base, input int k);
    return (int'(base) + k) % N_CH;
  endfunction

  // First pending channel at or after rr_ptr wins the single write slot.
  always_comb begin
    win_vld = 1'b0;
    win_ch  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!win_vld && pending[rr_idx(rr_ptr, k)]) begin
        win_vld = 1'b1;
        win_ch  = CH_W'(rr_idx(rr_ptr, k));
      end
    end
  end

  assign rr_next = (int'(win_ch) == N_CH - 1) ? '0 : CH_W'(int'(win_ch) + 1);

`ifdef HPTDC_FIFO_OVF_MARK_EN
  logic [15:0] ovf_cnt;
  logic [15:0] ovf_base;
  logic [16:0] ovf_sum;
  logic [31:0] mark_word;

  assign mark_sel  = (ovf_cnt != 16'd0);
  assign mark_word = {4'hE, 12'h000, ovf_cnt};
  assign wr_ent    = mark_sel ? {CH_W'(0), DATA_WIDTH'(mark_word)} : {win_ch, hold[win_ch]};

  // Drops seen in the marker's own write cycle start the next marker's count.
  assign ovf_base = (wr_en & mark_sel) ? 16'd0 : ovf_cnt;
  assign ovf_sum  = {1'b0, ovf_base} + n_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else begin
      ovf_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end
`else
  assign mark_sel = 1'b0;
  assign wr_ent   = {win_ch, hold[win_ch]};
`endif

  // Writes are gated on the registered full flag, so a slot freed by the head load is reused one clock later.
  assign wr_en = ~rst & ~flush & ~full & (win_vld | mark_sel);
  assign ld    = ~rst & ~flush & (~rd_valid | rd_ready) & (level != '0);

  always_comb begin
    grant = '0;
    if (wr_en && !mark_sel) begin
      grant[win_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (capture[i]) begin
        hold[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_ent;
    end
  end

  always_ff @(posedge clk) begin
    // Loaded during reset as well, so a level held high through reset is not an edge.
    prev_ready <= ch_ready;
    if (rst) begin
      pending    <= '0;
      rr_ptr     <= '0;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_channel <= '0;
      drop_cnt   <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (flush) begin
        pending  <= '0;
        wptr     <= '0;
        rptr     <= '0;
        level    <= '0;
        rd_valid <= 1'b0;
      end else begin
        pending <= (pending | capture) & ~grant;
        if (wr_en) begin
          wptr <= wptr + 1'b1;
        end
        if (grant != '0) begin
          rr_ptr <= rr_next;
        end
        if (ld) begin
          {rd_channel, rd_data} <= mem[rptr];
          rptr     <= rptr + 1'b1;
          rd_valid <= 1'b1;
        end else if (rd_ready) begin
          rd_valid <= 1'b0;
        end
        case ({wr_en, ld})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  assign empty       = (level == '0);
  assign full        = (level == (ADDR_WIDTH+1)'(DEPTH));
  assign almost_full = (int'(level) >= AFULL_LEVEL);

endmodule

// File: tb/tb_hptdc_readout_fifo.sv
// Directed bench for hptdc_readout_fifo with a 4-entry FIFO and two channels.
module tb_hptdc_readout_fifo;

  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_ready;
  logic [NCH-1:0]    ch_get;
  logic              rd_valid;
  logic              rd_ready;
  logic [DW-1:0]     rd_data;
  logic [0:0]        rd_channel;
  logic [AW:0]       level;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [15:0]       drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] exp_ch [$];

  hptdc_readout_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .N_CH       (NCH),
    .ACCEPT_TYPE(3'b010),
    .AFULL_LEVEL(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .ch_get     (ch_get),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_channel (rd_channel),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ch_data = '0; ch_ready = 2'b11; rd_ready = 1'b0;
    ch_data[DW-1:0]    = 32'h4000_0055;
    ch_data[2*DW-1:DW] = 32'h4000_0066;
    step(); step();
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_channel", 32'(rd_channel), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_ch_get", 32'(ch_get), 32'h3);

    // Ready held high through reset must not capture.
    rst = 1'b0;
    step(); step(); step();
    chk("held_ready_level", 32'(level), 0);
    chk("held_ready_valid", 32'(rd_valid), 0);
    chk("held_ready_get", 32'(ch_get), 32'h3);
    ch_ready = 2'b00;
    step();

    // Single accepted word on ch0.
    ch_data[DW-1:0] = 32'h4000_1234;
    ch_ready = 2'b01;
    step();
    chk("single_pending_get", 32'(ch_get), 32'h0);
    chk("single_level_n", 32'(level), 0);
    ch_ready = 2'b00;
    step();
    chk("single_level_n1", 32'(level), 1);
    chk("single_valid_n1", 32'(rd_valid), 0);
    step();
    chk("single_valid", 32'(rd_valid), 1);
    chk("single_data", rd_data, 32'h4000_1234);
    chk("single_chan", 32'(rd_channel), 0);
    chk("single_level", 32'(level), 0);
    rd_ready = 1'b1;
    step();
    chk("single_after_hs_valid", 32'(rd_valid), 0);
    chk("single_after_hs_empty", 32'(empty), 1);
    rd_ready = 1'b0;

    // Wrong type on ch1 is ignored and not counted.
    ch_data[2*DW-1:DW] = 32'h6000_0001;
    ch_ready = 2'b10;
    step(); step(); step();
    chk("badtype_level", 32'(level), 0);
    chk("badtype_valid", 32'(rd_valid), 0);
    chk("badtype_drop", 32'(drop_cnt), 0);
    ch_ready = 2'b00;
    step();

    // Simultaneous pair with rr_ptr=1 (ch0 won last): ch1 then ch0.
    rd_ready = 1'b1;
    ch_data[DW-1:0]    = 32'h4000_00A0;
    ch_data[2*DW-1:DW] = 32'h4000_00B1;
    ch_ready = 2'b11;
    step();
    ch_ready = 2'b00;
    step(); step();
    chk("pair1_first_data", rd_data, 32'h4000_00B1);
    chk("pair1_first_chan", 32'(rd_channel), 1);
    chk("pair1_first_valid", 32'(rd_valid), 1);
    step();
    chk("pair1_second_data", rd_data, 32'h4000_00A0);
    chk("pair1_second_chan", 32'(rd_channel), 0);
    step();
    chk("pair1_drained", 32'(rd_valid), 0);

    // Lone ch1 word moves the pointer back to ch0.
    ch_data[2*DW-1:DW] = 32'h4000_00C1;
    ch_ready = 2'b10;
    step();
    ch_ready = 2'b00;
    step(); step();
    chk("lone_data", rd_data, 32'h4000_00C1);
    chk("lone_chan", 32'(rd_channel), 1);
    step();
    chk("lone_drained", 32'(rd_valid), 0);

    ch_data[DW-1:0]    = 32'h4000_00D0;
    ch_data[2*DW-1:DW] = 32'h4000_00E1;
    ch_ready = 2'b11;
    step();
    ch_ready = 2'b00;
    step(); step();
    chk("pair2_first_data", rd_data, 32'h4000_00D0);
    chk("pair2_first_chan", 32'(rd_channel), 0);
    step();
    chk("pair2_second_data", rd_data, 32'h4000_00E1);
    chk("pair2_second_chan", 32'(rd_channel), 1);
    step();
    chk("pair2_drained", 32'(rd_valid), 0);
    rd_ready = 1'b0;

    // Fill: output register + 4 RAM entries + 1 pending hold.
    for (int k = 0; k < 6; k++) begin
      ch_data[DW-1:0] = 32'h4000_0100 + 32'(k);
      ch_ready = 2'b01;
      step();
      ch_ready = 2'b00;
      step();
    end
    chk("fill_level", 32'(level), 4);
    chk("fill_full", 32'(full), 1);
    chk("fill_afull", 32'(almost_full), 1);
    chk("fill_out_valid", 32'(rd_valid), 1);
    chk("fill_out_data", rd_data, 32'h4000_0100);
    for (int k = 0; k < 3; k++) begin
      ch_data[DW-1:0] = 32'h4000_0106 + 32'(k);
      ch_ready = 2'b01;
      #1;
      chk("fill_pending_get", 32'(ch_get), 0);
      step();
      ch_ready = 2'b00;
      step();
    end
    chk("fill_drop_cnt", 32'(drop_cnt), 3);
    chk("fill_level_after_drop", 32'(level), 4);
    chk("fill_out_stable", rd_data, 32'h4000_0100);

    exp_q.push_back(32'h4000_0101); exp_ch.push_back(0);
    exp_q.push_back(32'h4000_0102); exp_ch.push_back(0);
    exp_q.push_back(32'h4000_0103); exp_ch.push_back(0);
    exp_q.push_back(32'h4000_0104); exp_ch.push_back(0);
`ifdef HPTDC_FIFO_OVF_MARK_EN
    exp_q.push_back(32'hE000_0003); exp_ch.push_back(0);
`endif
    exp_q.push_back(32'h4000_0105); exp_ch.push_back(0);

    rd_ready = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      step();
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", rd_data, exp_q[k]);
      chk("drain_chan", 32'(rd_channel), exp_ch[k]);
    end
    step();
    chk("drain_done_valid", 32'(rd_valid), 0);
    chk("drain_done_level", 32'(level), 0);
    chk("drain_done_empty", 32'(empty), 1);
    rd_ready = 1'b0;

    // Flush with a word held in the output register.
    ch_data[DW-1:0]    = 32'h4000_0200;
    ch_data[2*DW-1:DW] = 32'h4000_0201;
    ch_ready = 2'b11;
    step();
    ch_ready = 2'b00;
    step(); step(); step();
    chk("preflush_valid", 32'(rd_valid), 1);
    chk("preflush_level", 32'(level), 1);
    chk("preflush_data", rd_data, 32'h4000_0201);
    flush = 1'b1;
    ch_data[DW-1:0] = 32'h4000_0202;
    ch_ready = 2'b01;
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(rd_valid), 0);
    chk("flush_level", 32'(level), 0);
    chk("flush_drop_kept", 32'(drop_cnt), 3);
    step(); step(); step();
    chk("flush_edge_discarded_level", 32'(level), 0);
    chk("flush_edge_discarded_valid", 32'(rd_valid), 0);
    chk("flush_get", 32'(ch_get), 32'h1);

    // Reset while a word is presented.
    ch_ready = 2'b00;
    step();
    ch_data[DW-1:0] = 32'h4000_0300;
    ch_ready = 2'b01;
    step(); step(); step();
    chk("prerst_valid", 32'(rd_valid), 1);
    chk("prerst_data", rd_data, 32'h4000_0300);
    rst = 1'b1;
    ch_ready = 2'b11;
    step();
    chk("midrst_valid", 32'(rd_valid), 0);
    chk("midrst_data", rd_data, 0);
    chk("midrst_drop", 32'(drop_cnt), 0);
    chk("midrst_level", 32'(level), 0);
    rst = 1'b0;
    step(); step(); step();
    chk("postrst_valid", 32'(rd_valid), 0);
    chk("postrst_level", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
